// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a 16:1 one-bit mux, with one-hot grant and valid.
// Optional forced rotation after MAX_HOLD cycles is built only when ARB_TIMEOUT_EN is defined.
module mux16_rr_arbiter #(
    parameter int N        = 16,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             preempt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    generate
        if (N != 16 || SEL_W != 4) begin : g_bad_size
            $error("mux16_rr_arbiter: N must be 16 and SEL_W must be 4");
        end
        if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
            $error("mux16_rr_arbiter: MAX_HOLD must be in 2..255");
        end
    endgenerate

    // Returns {found, index} of the first request at start, start+1, ... over span positions.
    function automatic logic [SEL_W:0] f_search(
        input logic [N-1:0]     r,
        input logic [SEL_W-1:0] start,
        input int               span
    );
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = start + SEL_W'(i);
            if (i < span && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [N-1:0] f_onehot(input logic [SEL_W-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t           r_state;
    logic [N-1:0]     r_gnt;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic [SEL_W-1:0] r_ptr;

    logic [SEL_W-1:0] w_next_ptr;
    logic [SEL_W:0]   w_idle_win;
    logic [SEL_W:0]   w_rot_win;
    logic             w_cur_req;

    assign w_next_ptr = r_sel + SEL_W'(1);
    assign w_cur_req  = req[r_sel];
    assign w_idle_win = f_search(req, r_ptr, N);
    // Scanning N-1 slots from sel+1 leaves the current holder out of the search.
    assign w_rot_win  = f_search(req, w_next_ptr, N - 1);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold_cnt;
    logic       r_preempt;
    logic       w_timeout;

    assign w_timeout = (r_hold_cnt == 8'(MAX_HOLD - 1)) && w_rot_win[SEL_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_valid    <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_preempt  <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_idle_win[SEL_W]) begin
                        r_state    <= S_GRANT;
                        r_sel      <= w_idle_win[SEL_W-1:0];
                        r_gnt      <= f_onehot(w_idle_win[SEL_W-1:0]);
                        r_valid    <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (!w_cur_req) begin
                        r_ptr <= w_next_ptr;
                        if (w_rot_win[SEL_W]) begin
                            r_sel      <= w_rot_win[SEL_W-1:0];
                            r_gnt      <= f_onehot(w_rot_win[SEL_W-1:0]);
                            r_hold_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_gnt   <= '0;
                            r_valid <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_ptr      <= w_next_ptr;
                        r_sel      <= w_rot_win[SEL_W-1:0];
                        r_gnt      <= f_onehot(w_rot_win[SEL_W-1:0]);
                        r_hold_cnt <= '0;
                        r_preempt  <= 1'b1;
                    end else if (r_hold_cnt != 8'hFF) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign preempt = r_preempt;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_idle_win[SEL_W]) begin
                        r_state <= S_GRANT;
                        r_sel   <= w_idle_win[SEL_W-1:0];
                        r_gnt   <= f_onehot(w_idle_win[SEL_W-1:0]);
                        r_valid <= 1'b1;
                    end
                end
                S_GRANT: begin
                    // A grant without timeout ends only when its requester lets go.
                    if (!w_cur_req) begin
                        r_ptr <= w_next_ptr;
                        if (w_rot_win[SEL_W]) begin
                            r_sel <= w_rot_win[SEL_W-1:0];
                            r_gnt <= f_onehot(w_rot_win[SEL_W-1:0]);
                        end else begin
                            r_state <= S_IDLE;
                            r_gnt   <= '0;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign preempt = 1'b0;
`endif

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;

    a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(r_gnt));
    a_sel_matches : assert property (@(posedge clk) r_valid |-> (r_gnt == f_onehot(r_sel)));
    a_idle_no_gnt : assert property (@(posedge clk) !r_valid |-> (r_gnt == '0));

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter: directed steps queue expected outputs, a monitor checks them.
// Expectations for the forced-rotation scenario follow ARB_TIMEOUT_EN.
module tb_mux16_rr_arbiter;

    typedef struct {
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        valid;
        logic        preempt;
        int          step_no;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        valid;
    logic        preempt;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   n_steps;

    mux16_rr_arbiter #(
        .N        (16),
        .SEL_W    (4),
        .MAX_HOLD (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue what the outputs must be after the next rising edge.
    task automatic step(input logic rn, input logic [15:0] r, input logic [15:0] eg,
                        input logic [3:0] es, input logic ev, input logic ep);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        req   = r;
        e.gnt = eg; e.sel = es; e.valid = ev; e.preempt = ep; e.step_no = n_steps;
        exp_q.push_back(e);
        n_steps++;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (gnt !== e.gnt) begin
                n_errors++;
                $display("FAIL gnt step=%0d got=%h want=%h", e.step_no, gnt, e.gnt);
            end
            n_checks++;
            if (sel !== e.sel) begin
                n_errors++;
                $display("FAIL sel step=%0d got=%0d want=%0d", e.step_no, sel, e.sel);
            end
            n_checks++;
            if (valid !== e.valid) begin
                n_errors++;
                $display("FAIL valid step=%0d got=%b want=%b", e.step_no, valid, e.valid);
            end
            n_checks++;
            if (preempt !== e.preempt) begin
                n_errors++;
                $display("FAIL preempt step=%0d got=%b want=%b", e.step_no, preempt, e.preempt);
            end
        end
    end

    initial begin
        logic [15:0] mask;
        logic [3:0]  idx;
        logic        ep;
        n_checks = 0;
        n_errors = 0;
        n_steps  = 0;
        rst_n    = 1'b0;
        req      = 16'h0000;

        // Reset with every request high, then the first grant goes to input 0.
        step(1'b0, 16'hFFFF, 16'h0000, 4'd0, 1'b0, 1'b0);
        step(1'b0, 16'hFFFF, 16'h0000, 4'd0, 1'b0, 1'b0);
        step(1'b1, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 1'b0);
        step(1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);

        // Single requester 5: one-cycle latency, four granted cycles, sel kept after release.
        step(1'b1, 16'h0020, 16'h0020, 4'd5, 1'b1, 1'b0);
        step(1'b1, 16'h0020, 16'h0020, 4'd5, 1'b1, 1'b0);
        step(1'b1, 16'h0020, 16'h0020, 4'd5, 1'b1, 1'b0);
        step(1'b1, 16'h0020, 16'h0020, 4'd5, 1'b1, 1'b0);
        step(1'b1, 16'h0000, 16'h0000, 4'd5, 1'b0, 1'b0);

        // Wrap-around between inputs 0 and 15 without an idle bubble.
        step(1'b0, 16'h8001, 16'h0000, 4'd0, 1'b0, 1'b0);
        step(1'b1, 16'h8001, 16'h0001, 4'd0, 1'b1, 1'b0);
        step(1'b1, 16'h8001, 16'h0001, 4'd0, 1'b1, 1'b0);
        step(1'b1, 16'h8000, 16'h8000, 4'd15, 1'b1, 1'b0);
        step(1'b1, 16'h8000, 16'h8000, 4'd15, 1'b1, 1'b0);
        step(1'b1, 16'h0001, 16'h0001, 4'd0, 1'b1, 1'b0);
        step(1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);

        // Late request for 1 is ignored while 2 holds, then served after 2 releases.
        step(1'b1, 16'h0004, 16'h0004, 4'd2, 1'b1, 1'b0);
        step(1'b1, 16'h0006, 16'h0004, 4'd2, 1'b1, 1'b0);
        step(1'b1, 16'h0002, 16'h0002, 4'd1, 1'b1, 1'b0);
        step(1'b1, 16'h0000, 16'h0000, 4'd1, 1'b0, 1'b0);

        // All sixteen request; each lets go after two granted cycles.
        step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            mask = 16'hFFFF << i;
            idx  = 4'(i);
            step(1'b1, mask, 16'h0001 << i, idx, 1'b1, 1'b0);
            step(1'b1, mask, 16'h0001 << i, idx, 1'b1, 1'b0);
        end
        step(1'b1, 16'h0000, 16'h0000, 4'd15, 1'b0, 1'b0);

        // Inputs 3 and 9 both held: alternate every 8 cycles with timeout, else 3 keeps the grant.
        step(1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < 32; c++) begin
`ifdef ARB_TIMEOUT_EN
            idx = (((c / 8) % 2) == 1) ? 4'd9 : 4'd3;
            ep  = ((c % 8) == 0) && (c >= 8);
`else
            idx = 4'd3;
            ep  = 1'b0;
`endif
            step(1'b1, 16'h0208, 16'h0001 << idx, idx, 1'b1, ep);
        end
        step(1'b1, 16'h0000, 16'h0000, 4'd3, 1'b0, 1'b0);

        // Reset in the middle of a grant to 7, then re-grant one cycle after release of reset.
        step(1'b1, 16'h0080, 16'h0080, 4'd7, 1'b1, 1'b0);
        step(1'b1, 16'h0080, 16'h0080, 4'd7, 1'b1, 1'b0);
        step(1'b0, 16'h0080, 16'h0000, 4'd0, 1'b0, 1'b0);
        step(1'b1, 16'h0080, 16'h0080, 4'd7, 1'b1, 1'b0);
        step(1'b1, 16'h0000, 16'h0000, 4'd7, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
